bus_ctrl55: RTL and testbench
=============================

# bus_ctrl55

Bus controller directly downstream of the cpu55 core. It takes the core's single-beat bus requests and carries them out one at a time on a variable-latency memory/peripheral port. Writes are posted through a one-entry write buffer. Reads stall the core until data returns. A transaction that gets no response is aborted by a timeout, which sets a sticky error flag.

## Interface
Parameters:
- TIMEOUT, 15, maximum cycles `mem_en` may stay high without `mem_ack` before the transaction is aborted (≥2)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- cpu_bc_req  in  1  core request valid
- cpu_bc_rw  in  1  1 = write, 0 = read
- cpu_bc_addr  in  32  request address
- cpu_bc_data  in  32  write data
- bc_cpu_data  out  32  read data (registered)
- bc_cpu_stall  out  1  core must hold its request stable (combinational)
- mem_en  out  1  memory transaction active (registered)
- mem_we  out  1  1 = write transaction (registered)
- mem_addr  out  32  memory address (registered)
- mem_wdata  out  32  memory write data (registered)
- mem_rdata  in  32  memory read data, valid while `mem_ack`=1
- mem_ack  in  1  memory completion; only sampled while `mem_en`=1
- bus_err  out  1  sticky timeout flag; cleared only by reset

## Operation
- **Write buffer:** one entry holding `wb_valid`, `wb_addr` and `wb_data`.
- **Write acceptance:** a write request is accepted when `wb_valid`=0. The buffer loads at that edge and the stall stays low.
  - If `wb_valid`=1, the stall is high.
  - There is no bypass: a write is stalled even when the buffered write completes in the same cycle.
- **Read ordering:** a read is issued only when `wb_valid`=0 and the engine is in M_IDLE. A pending buffered write always drains before any read is issued.
- **Engine states:** M_IDLE, M_WRITE, M_READ, M_RESP.
  - **M_IDLE:**
    - If `wb_valid`, go to M_WRITE with `mem_en`=1, `mem_we`=1, `mem_addr`/`mem_wdata` taken from the buffer.
    - Otherwise, if `cpu_bc_req`=1 and `cpu_bc_rw`=0, go to M_READ with `mem_en`=1, `mem_we`=0, `mem_addr`=`cpu_bc_addr`.
    - Otherwise, stay in M_IDLE.
  - **M_WRITE:**
    - On `mem_ack`: go to M_IDLE, `mem_en`=0, `wb_valid`=0.
    - On timeout: do the same and also set `bus_err`=1. The write is dropped.
  - **M_READ:**
    - On `mem_ack`: `bc_cpu_data`=`mem_rdata`, go to M_RESP, `mem_en`=0.
    - On timeout: `bc_cpu_data`=32'hFFFF_FFFF, `bus_err`=1, go to M_RESP.
  - **M_RESP:** unconditionally return to M_IDLE at the next edge.
- **Stall equation:** `bc_cpu_stall` = `cpu_bc_req` & (`cpu_bc_rw` ? `wb_valid` : (state != M_RESP)).
- **Timeout counter:**
  - Width is $clog2(TIMEOUT+1). It is cleared on entry to M_WRITE or M_READ and increments each cycle in those states without `mem_ack`.
  - If the counter equals TIMEOUT-1 and `mem_ack`=0 at an edge, the transaction aborts.
  - An ack in the TIMEOUT-th cycle is honoured normally.
- **Late ack:** `mem_ack` arriving in M_IDLE or M_RESP is ignored.

## Timing
- **Reset values:** while `rst`=0 at an edge, state → M_IDLE and `wb_valid`=0. All registered outputs go to 0: `bc_cpu_data`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `bus_err`.
- **Reset mid-transaction:** the transaction is abandoned. `mem_en` is 0 in the first cycle after the reset edge and the buffered write is lost.
- **Write latency:** request at edge E (buffer empty, engine idle) → `mem_en` high in cycle E+1 → a zero-wait ack in that cycle frees the buffer at edge E+2. The core sees no stall.
- **Read latency:** request seen in cycle N with the engine idle and buffer empty.
  - `mem_en` rises in cycle N+1; an ack in cycle N+1 gives M_RESP in cycle N+2, where the stall drops and `bc_cpu_data` is valid.
  - Minimum is 2 stall cycles; each memory wait cycle adds one.
- **Back-to-back reads:** minimum is one read every 3 cycles (M_READ, M_RESP, M_IDLE).
- **Read after write:** the read's `mem_en` rises no earlier than the cycle after the write's ack edge.
- **Timeout duration:** an aborted transaction holds `mem_en` high for exactly TIMEOUT cycles.
- **Core contract:** the core must hold `cpu_bc_req`, `cpu_bc_rw`, `cpu_bc_addr` and `cpu_bc_data` stable while `bc_cpu_stall`=1.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with random inputs → all outputs 0 and `bc_cpu_stall`=`cpu_bc_req`&~`cpu_bc_rw`; then `rst`=1 with a write request → accepted with no stall.
- **Posted write:** write 0x0000_0010 ← 0xA5A5_5A5A with ack after 3 waits → no core stall; `mem_en` high 4 cycles with `mem_we`=1 and correct addr/data; `wb_valid` clears after the ack edge.
- **Write then read:** two writes back-to-back, the second while the first waits 5 cycles → second stalls until the buffer frees. A read of 0x10 then issues only after the second write's ack, and `bc_cpu_data`=`mem_rdata`=0x1234_5678 in the M_RESP cycle.
- **Zero-wait reads:** 3 reads with ack in the first `mem_en` cycle → each stalls exactly 2 cycles; `mem_en` pulses spaced 3 cycles apart.
- **Read timeout:** TIMEOUT=15 with no ack → `mem_en` high exactly 15 cycles, then `bc_cpu_data`=0xFFFF_FFFF, stall drops, `bus_err`=1 and stays 1. A late ack 2 cycles later is ignored. An ack in cycle 15 of a separate read completes normally.
- **Reset mid-read:** `rst`=0 during cycle 2 of a pending read → `mem_en`=0 the next cycle, state M_IDLE, `bus_err` cleared.

Source files
------------

// File: rtl/bus_ctrl55_if.sv
// ---------------------------------------------------------------------------
// bus_ctrl55_if
// Groups the core-side request/response signals and the memory-side
// transaction signals of bus_ctrl55 into one bundle.
//
//   cpu_bc_req/rw/addr/data : core request (driven by core)
//   bc_cpu_data             : read data returned to the core
//   bc_cpu_stall            : core must hold its request stable
//   mem_en/we/addr/wdata    : memory transaction (driven by controller)
//   mem_rdata/mem_ack       : memory response (driven by memory)
//   bus_err                 : sticky timeout flag
//
// Modports: slave  - the controller's view (serves core requests)
//           master - the environment's view (core + memory)
// ---------------------------------------------------------------------------
interface bus_ctrl55_if;
  logic        cpu_bc_req;
  logic        cpu_bc_rw;
  logic [31:0] cpu_bc_addr;
  logic [31:0] cpu_bc_data;
  logic [31:0] bc_cpu_data;
  logic        bc_cpu_stall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  modport slave (
    input  cpu_bc_req, cpu_bc_rw, cpu_bc_addr, cpu_bc_data,
    input  mem_rdata, mem_ack,
    output bc_cpu_data, bc_cpu_stall,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output bus_err
  );

  modport master (
    output cpu_bc_req, cpu_bc_rw, cpu_bc_addr, cpu_bc_data,
    output mem_rdata, mem_ack,
    input  bc_cpu_data, bc_cpu_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  bus_err
  );
endinterface

// File: rtl/bus_ctrl55.sv
// ---------------------------------------------------------------------------
// bus_ctrl55
// Executes single-beat core requests one at a time on a variable-latency
// memory port. Writes are posted into a one-entry buffer; reads stall the
// core until data (or a timeout) returns. A transaction that sees no ack for
// TIMEOUT cycles is aborted and sets the sticky bus_err flag.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active low
//   bus  - bus_ctrl55_if.slave (core request/response + memory port)
// ---------------------------------------------------------------------------
module bus_ctrl55 #(
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  bus_ctrl55_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {M_IDLE, M_WRITE, M_READ, M_RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wb_valid_q, wb_valid_d;
  logic [31:0]   wb_addr_q, wb_addr_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          en_q, en_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          expired;

  // Abort fires on the last allowed cycle only if the memory stays silent;
  // an ack in that same cycle wins.
  assign expired = (cnt_q == CNT_LAST) && !bus.mem_ack;

  // Reads hold the core until the response cycle; writes only while the
  // buffer is occupied (no bypass on the draining cycle).
  assign bus.bc_cpu_stall = bus.cpu_bc_req &
                            (bus.cpu_bc_rw ? wb_valid_q : (state_q != M_RESP));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    en_d       = en_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;

    // Buffer load and buffer drain are mutually exclusive: loading needs an
    // empty buffer, draining happens only in M_WRITE with a full one.
    if (bus.cpu_bc_req && bus.cpu_bc_rw && !wb_valid_q) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = bus.cpu_bc_addr;
      wb_data_d  = bus.cpu_bc_data;
    end

    unique case (state_q)
      M_IDLE: begin
        if (wb_valid_q) begin
          state_d = M_WRITE;
          en_d    = 1'b1;
          we_d    = 1'b1;
          addr_d  = wb_addr_q;
          wdata_d = wb_data_q;
          cnt_d   = '0;
        end else if (bus.cpu_bc_req && !bus.cpu_bc_rw) begin
          state_d = M_READ;
          en_d    = 1'b1;
          we_d    = 1'b0;
          addr_d  = bus.cpu_bc_addr;
          cnt_d   = '0;
        end
      end
      M_WRITE: begin
        if (bus.mem_ack || expired) begin
          state_d    = M_IDLE;
          en_d       = 1'b0;
          wb_valid_d = 1'b0;
          if (!bus.mem_ack) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      M_READ: begin
        if (bus.mem_ack) begin
          state_d = M_RESP;
          en_d    = 1'b0;
          rdata_d = bus.mem_rdata;
        end else if (expired) begin
          state_d = M_RESP;
          en_d    = 1'b0;
          rdata_d = 32'hFFFF_FFFF;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      M_RESP: state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= M_IDLE;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      en_q       <= en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign bus.mem_en      = en_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.bc_cpu_data = rdata_q;
  assign bus.bus_err     = err_q;

endmodule

// File: tb/tb_bus_ctrl55.sv
// ---------------------------------------------------------------------------
// tb_bus_ctrl55
// Directed bench for bus_ctrl55 (TIMEOUT = 15). Inputs change 1 ns after
// each rising edge and outputs are checked 1 ns later, so registered outputs
// reflect the current cycle and the combinational stall has settled.
// ---------------------------------------------------------------------------
module tb_bus_ctrl55;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bus_ctrl55_if bif ();

  bus_ctrl55 #(.TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu(input logic req, input logic rw,
                     input logic [31:0] a, input logic [31:0] d);
    bif.cpu_bc_req  = req;
    bif.cpu_bc_rw   = rw;
    bif.cpu_bc_addr = a;
    bif.cpu_bc_data = d;
  endtask

  initial begin
    // ---------------- reset with random inputs ----------------
    rst           = 1'b0;
    cpu(1'b1, 1'b0, $urandom(), $urandom());
    bif.mem_rdata = $urandom();
    bif.mem_ack   = 1'($urandom_range(0, 1));
    tick();
    tick();
    bif.mem_ack = 1'b0;
    settle();
    check("rst_en",    32'(bif.mem_en), 32'd0);
    check("rst_we",    32'(bif.mem_we), 32'd0);
    check("rst_addr",  bif.mem_addr, 32'd0);
    check("rst_wdata", bif.mem_wdata, 32'd0);
    check("rst_rdata", bif.bc_cpu_data, 32'd0);
    check("rst_err",   32'(bif.bus_err), 32'd0);
    check("rst_stall_rd", 32'(bif.bc_cpu_stall), 32'd1);

    // ---------------- posted write, 3 wait cycles ----------------
    rst = 1'b1;
    cpu(1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_5A5A);
    settle();
    check("rst_stall_wr", 32'(bif.bc_cpu_stall), 32'd0);
    tick();
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check("pw_en_pre", 32'(bif.mem_en), 32'd0);
    for (int w = 0; w < 4; w++) begin
      tick();
      bif.mem_ack = (w == 3);
      settle();
      check("pw_en",    32'(bif.mem_en), 32'd1);
      check("pw_we",    32'(bif.mem_we), 32'd1);
      check("pw_addr",  bif.mem_addr, 32'h0000_0010);
      check("pw_wdata", bif.mem_wdata, 32'hA5A5_5A5A);
    end

    // ---------------- two writes, then a read ----------------
    tick();
    bif.mem_ack = 1'b0;
    cpu(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    settle();
    check("pw_en_post", 32'(bif.mem_en), 32'd0);
    check("w1_stall",   32'(bif.bc_cpu_stall), 32'd0);
    tick();
    cpu(1'b1, 1'b1, 32'h0000_0104, 32'hCAFE_F00D);
    settle();
    check("w2_stall_idle", 32'(bif.bc_cpu_stall), 32'd1);
    check("w1_en_pre",     32'(bif.mem_en), 32'd0);
    for (int w = 0; w < 6; w++) begin
      tick();
      bif.mem_ack = (w == 5);
      settle();
      check("w1_en",    32'(bif.mem_en), 32'd1);
      check("w1_addr",  bif.mem_addr, 32'h0000_0100);
      check("w1_wdata", bif.mem_wdata, 32'hDEAD_BEEF);
      check("w2_stall", 32'(bif.bc_cpu_stall), 32'd1);
    end
    tick();
    bif.mem_ack = 1'b0;
    settle();
    check("w1_en_post",   32'(bif.mem_en), 32'd0);
    check("w2_accept",    32'(bif.bc_cpu_stall), 32'd0);
    tick();
    cpu(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    settle();
    check("rd_stall_wb",  32'(bif.bc_cpu_stall), 32'd1);
    check("rd_en_wb",     32'(bif.mem_en), 32'd0);
    tick();
    bif.mem_ack = 1'b1;
    settle();
    check("w2_en",    32'(bif.mem_en), 32'd1);
    check("w2_we",    32'(bif.mem_we), 32'd1);
    check("w2_addr",  bif.mem_addr, 32'h0000_0104);
    check("w2_wdata", bif.mem_wdata, 32'hCAFE_F00D);
    tick();
    bif.mem_ack = 1'b0;
    settle();
    check("rd_en_gap",   32'(bif.mem_en), 32'd0);
    check("rd_stall_gap", 32'(bif.bc_cpu_stall), 32'd1);
    tick();
    bif.mem_ack   = 1'b1;
    bif.mem_rdata = 32'h1234_5678;
    settle();
    check("rd_en",   32'(bif.mem_en), 32'd1);
    check("rd_we",   32'(bif.mem_we), 32'd0);
    check("rd_addr", bif.mem_addr, 32'h0000_0010);
    tick();
    bif.mem_ack   = 1'b0;
    bif.mem_rdata = 32'h0;
    settle();
    check("rd_stall_resp", 32'(bif.bc_cpu_stall), 32'd0);
    check("rd_data",       bif.bc_cpu_data, 32'h1234_5678);
    check("rd_en_resp",    32'(bif.mem_en), 32'd0);

    // ---------------- zero-wait reads ----------------
    for (int k = 0; k < 3; k++) begin
      tick();
      cpu(1'b1, 1'b0, 32'h0000_0200 + 32'(4 * k), 32'h0);
      settle();
      check("zr_stall0", 32'(bif.bc_cpu_stall), 32'd1);
      check("zr_en0",    32'(bif.mem_en), 32'd0);
      tick();
      bif.mem_ack   = 1'b1;
      bif.mem_rdata = 32'h0000_0A00 + 32'(k);
      settle();
      check("zr_en1",    32'(bif.mem_en), 32'd1);
      check("zr_addr",   bif.mem_addr, 32'h0000_0200 + 32'(4 * k));
      check("zr_stall1", 32'(bif.bc_cpu_stall), 32'd1);
      tick();
      bif.mem_ack = 1'b0;
      settle();
      check("zr_stall2", 32'(bif.bc_cpu_stall), 32'd0);
      check("zr_data",   bif.bc_cpu_data, 32'h0000_0A00 + 32'(k));
      check("zr_en2",    32'(bif.mem_en), 32'd0);
    end

    // ---------------- read timeout ----------------
    tick();
    cpu(1'b1, 1'b0, 32'h0000_0300, 32'h0);
    settle();
    check("to_stall0", 32'(bif.bc_cpu_stall), 32'd1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      settle();
      check("to_en",    32'(bif.mem_en), 32'd1);
      check("to_stall", 32'(bif.bc_cpu_stall), 32'd1);
      check("to_err_early", 32'(bif.bus_err), 32'd0);
    end
    tick();
    settle();
    check("to_en_drop", 32'(bif.mem_en), 32'd0);
    check("to_stall_drop", 32'(bif.bc_cpu_stall), 32'd0);
    check("to_data",    bif.bc_cpu_data, 32'hFFFF_FFFF);
    check("to_err",     32'(bif.bus_err), 32'd1);
    tick();
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check("to_err_hold", 32'(bif.bus_err), 32'd1);
    tick();
    bif.mem_ack   = 1'b1;
    bif.mem_rdata = 32'hBAD0_BAD0;
    settle();
    check("late_en", 32'(bif.mem_en), 32'd0);
    tick();
    bif.mem_ack = 1'b0;
    settle();
    check("late_en2",  32'(bif.mem_en), 32'd0);
    check("late_data", bif.bc_cpu_data, 32'hFFFF_FFFF);
    check("late_err",  32'(bif.bus_err), 32'd1);

    // ---------------- ack in the last allowed cycle ----------------
    tick();
    cpu(1'b1, 1'b0, 32'h0000_0400, 32'h0);
    settle();
    check("l15_stall0", 32'(bif.bc_cpu_stall), 32'd1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      bif.mem_ack   = (i == 15);
      bif.mem_rdata = 32'h5555_AAAA;
      settle();
      check("l15_en",    32'(bif.mem_en), 32'd1);
      check("l15_stall", 32'(bif.bc_cpu_stall), 32'd1);
    end
    tick();
    bif.mem_ack = 1'b0;
    settle();
    check("l15_data",  bif.bc_cpu_data, 32'h5555_AAAA);
    check("l15_stall_drop", 32'(bif.bc_cpu_stall), 32'd0);
    check("l15_en_drop",    32'(bif.mem_en), 32'd0);
    check("l15_err_sticky", 32'(bif.bus_err), 32'd1);
    tick();
    cpu(1'b0, 1'b0, 32'h0, 32'h0);

    // ---------------- reset in the middle of a read ----------------
    tick();
    cpu(1'b1, 1'b0, 32'h0000_0500, 32'h0);
    tick();
    settle();
    check("mr_en1", 32'(bif.mem_en), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    settle();
    check("mr_en",    32'(bif.mem_en), 32'd0);
    check("mr_err",   32'(bif.bus_err), 32'd0);
    check("mr_data",  bif.bc_cpu_data, 32'd0);
    check("mr_addr",  bif.mem_addr, 32'd0);
    check("mr_stall", 32'(bif.bc_cpu_stall), 32'd1);
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    tick();
    settle();
    check("mr_idle_en", 32'(bif.mem_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
